paddle_renderer: RTL

- Parametrised paddle engine for the 160x120 VGA game: owns paddle position, moves it once per frame tick from left/right buttons, and streams erase/draw pixels (x, y, colour, plot) to vga_adapter.
- Generalises the single-row paddle to W x H rectangles with configurable step, bounds, frame rate and redraw mode.
- Exports committed position for ball collision logic.

---
 rtl/paddle_renderer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/paddle_renderer.sv
// Paddle engine for the 160x120 VGA game: steps a W x H paddle once per frame
// tick from the buttons and streams the erase/draw pixels to the VGA adapter.
module paddle_renderer #(
  parameter int         PADDLE_W      = 16,
  parameter int         PADDLE_H      = 2,
  parameter int         X_MIN         = 2,
  parameter int         X_MAX         = 157,
  parameter int         Y_POS         = 110,
  parameter int         X_INIT        = 50,
  parameter int         STEP          = 1,
  parameter int         FRAME_CYCLES  = 833333,
  parameter logic [2:0] FG_COLOUR     = 3'b111,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter bit         REDRAW_ALWAYS = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       left,
  input  logic       right,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [7:0] pos_x,
  output logic       busy,
  output logic       frame_done
);

  localparam int               CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [8:0]       X_LO     = 9'(X_MIN);
  localparam logic [8:0]       X_HI     = 9'(X_MAX - PADDLE_W + 1);
  localparam logic [8:0]       STEP9    = 9'(STEP);
  localparam logic [5:0]       PX_LAST  = 6'(PADDLE_W - 1);
  localparam logic [2:0]       PY_LAST  = 3'(PADDLE_H - 1);

  generate
    if (X_INIT < X_MIN || X_INIT > X_MAX - PADDLE_W + 1) begin : g_bad_init
      $error("paddle_renderer: X_INIT outside [X_MIN, X_MAX-PADDLE_W+1]");
    end
    if (X_MAX > 159) begin : g_bad_xmax
      $error("paddle_renderer: X_MAX beyond screen width");
    end
    if (Y_POS + PADDLE_H > 120) begin : g_bad_y
      $error("paddle_renderer: paddle extends below screen");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ERASE,
    S_UPDATE,
    S_DRAW
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       pos_x_q, pos_x_d;
  logic [7:0]       nx_q, nx_d;
  logic [5:0]       px_q, px_d;
  logic [2:0]       py_q, py_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             run_q, run_d;

  logic       tick_en;
  logic [8:0] sum9;
  logic [8:0] nx9;
  logic       last_px;

  // run_q holds off plotting until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_DRAW;
      pos_x_q   <= 8'(X_INIT);
      nx_q      <= 8'(X_INIT);
      px_q      <= '0;
      py_q      <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      nx_q      <= nx_d;
      px_q      <= px_d;
      py_q      <= py_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    nx_d       = nx_q;
    px_d       = px_q;
    py_d       = py_q;
    pending_d  = pending_q;
    run_d      = 1'b1;
    frame_done = 1'b0;

    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_en = (cnt_q == CNT_LAST) && enable;

    sum9 = {1'b0, pos_x_q} + STEP9;
    nx9  = {1'b0, pos_x_q};
    if (right && !left) begin
      nx9 = (sum9 > X_HI) ? X_HI : sum9;
    end else if (left && !right) begin
      nx9 = ({1'b0, pos_x_q} < X_LO + STEP9) ? X_LO : {1'b0, pos_x_q} - STEP9;
    end

    last_px = (px_q == PX_LAST) && (py_q == PY_LAST);

    // Only one tick can be held over while a redraw is in flight
    if (tick_en && state_q != S_IDLE) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tick_en || pending_q) begin
          pending_d = 1'b0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        nx_d = nx9[7:0];
        px_d = '0;
        py_d = '0;
        if (nx9 == {1'b0, pos_x_q} && !REDRAW_ALWAYS) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        if (run_q) begin
          if (px_q == PX_LAST) begin
            px_d = '0;
            py_d = py_q + 1'b1;
          end else begin
            px_d = px_q + 1'b1;
          end
          // New position becomes visible in the UPDATE cycle itself
          if (last_px) begin
            py_d = '0;
            if (state_q == S_ERASE) begin
              pos_x_d = nx_q;
              state_d = S_UPDATE;
            end else begin
              frame_done = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end
      end
      S_UPDATE: begin
        px_d    = '0;
        py_d    = '0;
        state_d = S_DRAW;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign plot   = run_q && (state_q == S_ERASE || state_q == S_DRAW);
  assign x      = pos_x_q + {2'b00, px_q};
  assign y      = 7'(Y_POS) + {4'b0000, py_q};
  assign colour = (state_q == S_DRAW) ? FG_COLOUR : BG_COLOUR;
  assign busy   = (state_q != S_IDLE);
  assign pos_x  = pos_x_q;

endmodule
